// File: rtl/digit_pkg.sv
// Shared constants for the digit page latch: page index geometry and word reset value.
package digit_pkg;

    localparam int PAGE_W     = 2;
    localparam int PAGE_COUNT = 4;

    localparam logic [31:0] WORD_RST = 32'h0;

    // The page index is exactly PAGE_W bits wide, so the modulo-4 wrap is the natural overflow.
    function automatic logic [PAGE_W-1:0] next_page(input logic [PAGE_W-1:0] p);
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces a raw push-button and emits a one-cycle pulse on each accepted press.
module btn_debounce
    import digit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    // Counter runs only while the synchronized level disagrees with the accepted one;
    // any return to the accepted level restarts the count from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/digit_page_latch.sv
// Holds the CPU display word and drives the byte selected by a button-paged index to the hex decoder.
module digit_page_latch
    import digit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    input  logic              btn,
    output logic [7:0]        digito_data,
    output logic [PAGE_W-1:0] page,
    output logic              valid
);

    logic              w_press;
    logic [31:0]       r_word;
    logic              r_valid;
    logic [PAGE_W-1:0] r_page;
    logic [7:0]        r_dig;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .press(w_press)
    );

    // The output byte is taken from the pre-edge word and page, so a write or page
    // advance shows up on digito_data one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word  <= WORD_RST;
            r_valid <= 1'b0;
            r_page  <= '0;
            r_dig   <= 8'h00;
        end else begin
            r_dig <= r_word[{r_page, 3'b000} +: 8];
            if (wr_en) begin
                r_word  <= wr_data;
                r_valid <= 1'b1;
            end
            if (w_press) begin
                r_page <= next_page(r_page);
            end
        end
    end

    assign digito_data = r_dig;
    assign page        = r_page;
    assign valid       = r_valid;

endmodule

// File: tb/tb_digit_page_latch.sv
// Self-checking bench for digit_page_latch: directed scenarios plus randomized traffic against a reference model.
module tb_digit_page_latch;

    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        btn;
    logic [7:0]  digito_data;
    logic [1:0]  page;
    logic        valid;

    int checks;
    int errors;
    int cyc;

    digit_page_latch #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .btn        (btn),
        .digito_data(digito_data),
        .page       (page),
        .valid      (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: button accepted once the last D synchronized samples all disagree with the accepted level.
    logic [31:0] m_word;
    logic        m_valid;
    int          m_page;
    logic [7:0]  m_dig;
    logic        m_s1, m_s2;
    logic        m_stable, m_stable_d;
    logic        s2hist[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_word = 32'h0; m_valid = 1'b0; m_page = 0; m_dig = 8'h00;
        m_s1 = 1'b0; m_s2 = 1'b0; m_stable = 1'b0; m_stable_d = 1'b0;
        s2hist.delete();
    endtask

    task automatic model_edge(input logic b, input logic w, input logic [31:0] d);
        logic pr;
        logic all_diff;
        pr    = m_stable & ~m_stable_d;
        m_dig = m_word[8*m_page +: 8];
        s2hist.push_back(m_s2);
        if (s2hist.size() > D) void'(s2hist.pop_front());
        m_stable_d = m_stable;
        if (s2hist.size() == D) begin
            all_diff = 1'b1;
            foreach (s2hist[i]) if (s2hist[i] == m_stable) all_diff = 1'b0;
            if (all_diff) m_stable = m_s2;
        end
        m_s2 = m_s1;
        m_s1 = b;
        if (pr) m_page = (m_page + 1) % 4;
        if (w) begin
            m_word  = d;
            m_valid = 1'b1;
        end
    endtask

    task automatic step(input logic b, input logic w, input logic [31:0] d);
        btn = b; wr_en = w; wr_data = d;
        @(posedge clk);
        model_edge(b, w, d);
        cyc++;
        @(negedge clk);
        check_eq("dig",   {24'h0, digito_data}, {24'h0, m_dig});
        check_eq("page",  {30'h0, page},        m_page);
        check_eq("valid", {31'h0, valid},       {31'h0, m_valid});
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        check_eq("rst_dig",   {24'h0, digito_data}, 32'h0);
        check_eq("rst_page",  {30'h0, page},        32'h0);
        check_eq("rst_valid", {31'h0, valid},       32'h0);
        model_reset();
        #1 rst = 1'b1;
    endtask

    // Clean press: high for hold cycles, then low long enough for the release to be accepted.
    task automatic press(input int hold);
        for (int i = 0; i < hold; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++)    step(1'b0, 1'b0, 32'h0);
    endtask

    int          saved_page;
    int          hold;
    logic        lvl;

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b0; btn = 1'b0; wr_en = 1'b0; wr_data = 32'h0;
        model_reset();
        #2;
        check_eq("por_dig",   {24'h0, digito_data}, 32'h0);
        check_eq("por_page",  {30'h0, page},        32'h0);
        check_eq("por_valid", {31'h0, valid},       32'h0);
        #5 rst = 1'b1;

        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0);

        // Restart edge numbering for the timed scenario.
        @(negedge clk);
        do_reset();
        cyc = 0;
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hA1B2C3D4);
        check_eq("valid_e5", {31'h0, valid}, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        check_eq("dig_e6", {24'h0, digito_data}, 32'hD4);
        for (int i = 7; i <= 9; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 10; i <= 15; i++) step(1'b1, 1'b0, 32'h0);
        check_eq("page_e15", {30'h0, page}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check_eq("page_e16", {30'h0, page}, 32'h1);
        step(1'b0, 1'b0, 32'h0);
        check_eq("dig_e17", {24'h0, digito_data}, 32'hC3);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        press(6); press(6); press(6);
        check_eq("wrap_page", {30'h0, page},        32'h0);
        check_eq("wrap_dig",  {24'h0, digito_data}, 32'hD4);

        // Bounce that never completes a count.
        saved_page = int'(page);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        check_eq("bounce_page", {30'h0, page}, saved_page);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
        check_eq("hold_page", {30'h0, page}, (saved_page + 1) % 4);

        // Write lands on the same edge the page advances 1->2.
        check_eq("pre_same_page", {30'h0, page}, 32'h1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h11223344);
        check_eq("same_page", {30'h0, page}, 32'h2);
        step(1'b0, 1'b0, 32'h0);
        check_eq("same_dig", {24'h0, digito_data}, 32'h22);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);
        press(6);
        check_eq("page3", {30'h0, page}, 32'h3);

        // Reset while the debounce count sits at 2.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        check_eq("post_rst_k5", {30'h0, page}, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check_eq("post_rst_k6", {30'h0, page}, 32'h1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

        // Randomized traffic: button levels held for random run lengths, sporadic writes.
        hold = 0; lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                lvl  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end
            hold--;
            if (i == 300) do_reset();
            step(lvl, ($urandom_range(0, 4) == 0), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
